// File: rtl/blue_io_pkg.sv
// Shared definitions for the blue_io memory-mapped peripherals:
// register addresses, identification word and bus data width.
package blue_io_pkg;

    localparam int unsigned IO_DATA_W = 16;

    typedef enum logic [1:0] {
        SWP_ADDR_STATE   = 2'd0,
        SWP_ADDR_CHANGED = 2'd1,
        SWP_ADDR_RAW     = 2'd2,
        SWP_ADDR_ID      = 2'd3
    } swp_addr_e;

    localparam logic [IO_DATA_W-1:0] SWP_ID = 16'hB1E0;

endpackage

// File: rtl/switch_port_if.sv
// Single-cycle read bus between the processor load path and switch_port.
interface switch_port_if;
    import blue_io_pkg::*;

    logic                 rd_req;
    logic [1:0]           rd_addr;
    logic [IO_DATA_W-1:0] rd_data;
    logic                 rd_valid;

    modport master (output rd_req, output rd_addr, input  rd_data, input  rd_valid);
    modport slave  (input  rd_req, input  rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/switch_port_debounce.sv
// switch_debounce: one switch bit -- 2-flop synchronizer followed by a
// counter-based debouncer that accepts a level after DEBOUNCE_CYCLES stable cycles.
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic stable,
    output logic raw,
    output logic change_pulse
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_differs;
    logic          w_accept;

    assign w_differs = (r_s2 != r_stable);
    assign w_accept  = w_differs && (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= sw_in;
            r_s2 <= r_s1;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable       = r_stable;
    assign raw          = r_s2;
    assign change_pulse = w_accept;
endmodule

// File: rtl/switch_port.sv
// switch_port: debounced board-switch input peripheral with sticky change
// register (clear-on-read) and 1-cycle read port. Define SWITCH_PORT_IRQ_EN for irq.
module switch_port
    import blue_io_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switches,
    switch_port_if.slave     bus,
    output logic             irq
);
    logic [WIDTH-1:0]     w_stable;
    logic [WIDTH-1:0]     w_raw;
    logic [WIDTH-1:0]     w_pulse;
    logic [WIDTH-1:0]     r_changed;
    logic                 w_clear;
    logic [IO_DATA_W-1:0] w_rd_mux;
    logic [IO_DATA_W-1:0] r_rd_data;
    logic                 r_rd_valid;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk          (clk),
            .rst          (rst),
            .sw_in        (switches[g]),
            .stable       (w_stable[g]),
            .raw          (w_raw[g]),
            .change_pulse (w_pulse[g])
        );
    end

    assign w_clear = bus.rd_req && (swp_addr_e'(bus.rd_addr) == SWP_ADDR_CHANGED);

    always_comb begin
        w_rd_mux = '0;
        case (swp_addr_e'(bus.rd_addr))
            SWP_ADDR_STATE:   w_rd_mux = IO_DATA_W'(w_stable);
            SWP_ADDR_CHANGED: w_rd_mux = IO_DATA_W'(r_changed);
            SWP_ADDR_RAW:     w_rd_mux = IO_DATA_W'(w_raw);
            SWP_ADDR_ID:      w_rd_mux = SWP_ID;
            default:          w_rd_mux = '0;
        endcase
    end

    // Set wins over clear: a pulse coincident with a clearing read survives for the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_changed  <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_changed  <= (r_changed & ~{WIDTH{w_clear}}) | w_pulse;
            r_rd_valid <= bus.rd_req;
            r_rd_data  <= bus.rd_req ? w_rd_mux : '0;
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;

`ifdef SWITCH_PORT_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_changed;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif
endmodule
